// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Two-requester round-robin arbiter for the write and read ports of
//            a shared single-cycle-latency RAM, with read-after-write hazard hold.
// Revision : 1.0
// ============================================================================
module ram_port_arbiter #(
    parameter int RAM_WIDTH = 16,
    parameter int ADDR_LINE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr0_valid,
    input  logic                 wr1_valid,
    output logic                 wr0_ready,
    output logic                 wr1_ready,
    input  logic [ADDR_LINE-1:0] wr0_addr,
    input  logic [ADDR_LINE-1:0] wr1_addr,
    input  logic [RAM_WIDTH-1:0] wr0_data,
    input  logic [RAM_WIDTH-1:0] wr1_data,
    input  logic                 rd0_valid,
    input  logic                 rd1_valid,
    output logic                 rd0_ready,
    output logic                 rd1_ready,
    input  logic [ADDR_LINE-1:0] rd0_addr,
    input  logic [ADDR_LINE-1:0] rd1_addr,
    output logic                 rd0_rvalid,
    output logic                 rd1_rvalid,
    output logic [RAM_WIDTH-1:0] rd_rdata,
    output logic                 ram_wr_en,
    output logic [ADDR_LINE-1:0] ram_wr_addr,
    output logic [RAM_WIDTH-1:0] ram_wr_data,
    output logic                 ram_rd_en,
    output logic [ADDR_LINE-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0] ram_rd_data
);

    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic                 r_tag;
    logic                 r_tag_valid;

    logic                 w_wr_gnt0;
    logic                 w_wr_gnt1;
    logic                 w_wr_any;
    logic [ADDR_LINE-1:0] w_wr_addr;
    logic [RAM_WIDTH-1:0] w_wr_data;
    logic                 w_rd_any;
    logic                 w_rd_cand1;
    logic [ADDR_LINE-1:0] w_rd_cand_addr;
    logic                 w_hazard;
    logic                 w_rd_gnt;
    logic                 w_rvalid_any;

    always_comb begin
        w_wr_gnt0 = !rst && wr0_valid && (!wr1_valid || !r_wr_ptr);
        w_wr_gnt1 = !rst && wr1_valid && (!wr0_valid || r_wr_ptr);
        w_wr_any  = w_wr_gnt0 || w_wr_gnt1;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (w_wr_gnt0) begin
            w_wr_addr = wr0_addr;
            w_wr_data = wr0_data;
        end else if (w_wr_gnt1) begin
            w_wr_addr = wr1_addr;
            w_wr_data = wr1_data;
        end

        w_rd_any       = rd0_valid || rd1_valid;
        w_rd_cand1     = rd1_valid && (!rd0_valid || r_rd_ptr);
        w_rd_cand_addr = w_rd_cand1 ? rd1_addr : rd0_addr;
        // A read hitting this cycle's write address waits one cycle so it sees the new data
        w_hazard       = w_wr_any && (w_rd_cand_addr == w_wr_addr);
        w_rd_gnt       = !rst && w_rd_any && !w_hazard;
    end

    assign wr0_ready   = w_wr_gnt0;
    assign wr1_ready   = w_wr_gnt1;
    assign ram_wr_en   = w_wr_any;
    assign ram_wr_addr = w_wr_addr;
    assign ram_wr_data = w_wr_data;

    assign rd0_ready   = w_rd_gnt && !w_rd_cand1;
    assign rd1_ready   = w_rd_gnt && w_rd_cand1;
    assign ram_rd_en   = w_rd_gnt;
    assign ram_rd_addr = w_rd_gnt ? w_rd_cand_addr : '0;

    // Tag gated by rst so a grant just before reset never surfaces
    assign rd0_rvalid   = !rst && r_tag_valid && !r_tag;
    assign rd1_rvalid   = !rst && r_tag_valid && r_tag;
    assign w_rvalid_any = rd0_rvalid || rd1_rvalid;
    assign rd_rdata     = w_rvalid_any ? ram_rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_tag       <= 1'b0;
            r_tag_valid <= 1'b0;
        end else begin
            if (w_wr_any) begin
                r_wr_ptr <= w_wr_gnt0;
            end
            if (w_rd_gnt) begin
                r_rd_ptr <= !w_rd_cand1;
            end
            r_tag_valid <= w_rd_gnt;
            r_tag       <= w_rd_cand1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Self-checking bench for ram_port_arbiter with a shared RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_port_arbiter;

    localparam int c_rw = 16;
    localparam int c_aw = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr0_valid, wr1_valid, wr0_ready, wr1_ready;
    logic [c_aw-1:0] wr0_addr, wr1_addr;
    logic [c_rw-1:0] wr0_data, wr1_data;
    logic            rd0_valid, rd1_valid, rd0_ready, rd1_ready;
    logic [c_aw-1:0] rd0_addr, rd1_addr;
    logic            rd0_rvalid, rd1_rvalid;
    logic [c_rw-1:0] rd_rdata;
    logic            ram_wr_en, ram_rd_en;
    logic [c_aw-1:0] ram_wr_addr, ram_rd_addr;
    logic [c_rw-1:0] ram_wr_data, ram_rd_data;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .RAM_WIDTH(c_rw),
        .ADDR_LINE(c_aw)
    ) u_dut (
        .clk(clk), .rst(rst),
        .wr0_valid(wr0_valid), .wr1_valid(wr1_valid),
        .wr0_ready(wr0_ready), .wr1_ready(wr1_ready),
        .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
        .wr0_data(wr0_data), .wr1_data(wr1_data),
        .rd0_valid(rd0_valid), .rd1_valid(rd1_valid),
        .rd0_ready(rd0_ready), .rd1_ready(rd1_ready),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_rvalid(rd0_rvalid), .rd1_rvalid(rd1_rvalid),
        .rd_rdata(rd_rdata),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // Shared RAM: one-cycle read latency, zero data when not reading
    bit [c_rw-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= ram_rd_en ? ram_mem[ram_rd_addr] : '0;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit [c_rw-1:0] ref_mem [256];
    int            m_wr_ptr = 0;
    int            m_rd_ptr = 0;
    int            m_pend = -1;
    logic [c_rw-1:0] m_pend_data = '0;
    logic [3:0]    acc;
    logic [1:0]    s_wr_rdy, s_rd_rdy, s_rv;
    logic [c_rw-1:0] s_rdata;
    logic          s_wr_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] v, input int ptr);
        if (v == 2'b11) return ptr;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    // Evaluate one cycle at the falling edge, then advance to just after the next rise
    task automatic step();
        logic [c_aw-1:0] wa [2];
        logic [c_rw-1:0] wd [2];
        logic [c_aw-1:0] ra [2];
        int              ww, cand, rw;
        logic [31:0]     e_rv, e_rdata;
        @(negedge clk);
        wa[0] = wr0_addr; wa[1] = wr1_addr;
        wd[0] = wr0_data; wd[1] = wr1_data;
        ra[0] = rd0_addr; ra[1] = rd1_addr;
        ww   = pick({wr1_valid, wr0_valid}, m_wr_ptr);
        cand = pick({rd1_valid, rd0_valid}, m_rd_ptr);
        rw   = cand;
        if (rst) begin
            ww = -1;
            rw = -1;
        end else if (ww >= 0 && cand >= 0 && ra[cand] == wa[ww]) begin
            rw = -1;
        end
        e_rv    = (!rst && m_pend >= 0) ? (32'd1 << m_pend) : 32'd0;
        e_rdata = (e_rv != 0) ? 32'(m_pend_data) : 32'd0;

        check("wr_ready", 32'({wr1_ready, wr0_ready}), ww >= 0 ? (32'd1 << ww) : 32'd0);
        check("ram_wr", 32'({ram_wr_en, ram_wr_addr, ram_wr_data}),
              ww >= 0 ? {7'd0, 1'b1, wa[ww], wd[ww]} : 32'd0);
        check("rd_ready", 32'({rd1_ready, rd0_ready}), rw >= 0 ? (32'd1 << rw) : 32'd0);
        check("ram_rd", 32'({ram_rd_en, ram_rd_addr}), rw >= 0 ? {23'd0, 1'b1, ra[rw]} : 32'd0);
        check("rvalid", 32'({rd1_rvalid, rd0_rvalid}), e_rv);
        check("rd_rdata", 32'(rd_rdata), e_rdata);

        s_wr_rdy = {wr1_ready, wr0_ready};
        s_rd_rdy = {rd1_ready, rd0_ready};
        s_rv     = {rd1_rvalid, rd0_rvalid};
        s_rdata  = rd_rdata;
        s_wr_en  = ram_wr_en;

        acc = '0;
        if (rst) begin
            m_wr_ptr = 0;
            m_rd_ptr = 0;
            m_pend   = -1;
        end else begin
            m_pend = rw;
            if (rw >= 0) begin
                m_pend_data = ref_mem[ra[rw]];
                m_rd_ptr    = 1 - rw;
                acc[2+rw]   = 1'b1;
            end
            if (ww >= 0) begin
                ref_mem[wa[ww]] = wd[ww];
                m_wr_ptr        = 1 - ww;
                acc[ww]         = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr0_valid = 1'b0; wr1_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        // Requests present during reset must not be granted
        wr0_valid = 1'b1; wr1_valid = 1'b1; rd0_valid = 1'b1; rd1_valid = 1'b1;
        wr0_addr = 8'h03; wr1_addr = 8'h04; rd0_addr = 8'h05; rd1_addr = 8'h06;
        wr0_data = 16'h1111; wr1_data = 16'h2222;
        @(posedge clk);
        #1;
        step();
        check("reset_ready", 32'({s_wr_rdy, s_rd_rdy, s_rv}), 32'd0);
        step();
        rst = 1'b0;
        idle_inputs();

        // Write then read-back by requester 1
        wr0_valid = 1'b1; wr0_addr = 8'h10; wr0_data = 16'hABCD;
        step();
        check("s1_wr0_ready", 32'(s_wr_rdy), 32'd1);
        wr0_valid = 1'b0; rd1_valid = 1'b1; rd1_addr = 8'h10;
        step();
        check("s1_rd1_ready", 32'(s_rd_rdy), 32'd2);
        rd1_valid = 1'b0;
        step();
        check("s1_rvalid", 32'(s_rv), 32'd2);
        check("s1_rdata", 32'(s_rdata), 32'hABCD);

        // Write contention alternates after reset
        do_reset();
        wr0_valid = 1'b1; wr1_valid = 1'b1; wr0_addr = 8'h30; wr1_addr = 8'h31;
        for (int k = 0; k < 4; k++) begin
            wr0_data = 16'(16'h0100 + k); wr1_data = 16'(16'h0200 + k);
            step();
            check("s2_wr_alt", 32'(s_wr_rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("s2_wr_en", 32'(s_wr_en), 32'd1);
        end
        idle_inputs();

        // Same-cycle read of the address being written is held one cycle
        wr0_valid = 1'b1; wr0_addr = 8'h20; wr0_data = 16'h1234;
        rd0_valid = 1'b1; rd0_addr = 8'h20;
        step();
        check("s3_wr_ready", 32'(s_wr_rdy), 32'd1);
        check("s3_rd_held", 32'(s_rd_rdy), 32'd0);
        wr0_valid = 1'b0;
        step();
        check("s3_rd_ready", 32'(s_rd_rdy), 32'd1);
        rd0_valid = 1'b0;
        step();
        check("s3_rvalid", 32'(s_rv), 32'd1);
        check("s3_rdata", 32'(s_rdata), 32'h1234);

        // Back-to-back read contention
        wr0_valid = 1'b1; wr0_addr = 8'h01; wr0_data = 16'h0001;
        step();
        wr0_addr = 8'h02; wr0_data = 16'h0002;
        step();
        wr0_valid = 1'b0;
        do_reset();
        rd0_addr = 8'h01; rd1_addr = 8'h02;
        for (int k = 0; k < 7; k++) begin
            rd0_valid = (k < 6); rd1_valid = (k < 6);
            step();
            if (k >= 1) begin
                check("s4_rvalid", 32'(s_rv), (k % 2 == 1) ? 32'd1 : 32'd2);
                check("s4_rdata", 32'(s_rdata), (k % 2 == 1) ? 32'h0001 : 32'h0002);
            end
        end
        idle_inputs();

        // Reset right after a read grant suppresses its response
        rd0_valid = 1'b1; rd0_addr = 8'h05;
        step();
        rd0_valid = 1'b0; rst = 1'b1;
        step();
        check("s5_rvalid", 32'(s_rv), 32'd0);
        rst = 1'b0;
        wr0_valid = 1'b1; wr1_valid = 1'b1; wr0_addr = 8'h40; wr1_addr = 8'h41;
        rd0_valid = 1'b1; rd1_valid = 1'b1; rd0_addr = 8'h50; rd1_addr = 8'h51;
        step();
        check("s5_wr_first", 32'(s_wr_rdy), 32'd1);
        check("s5_rd_first", 32'(s_rd_rdy), 32'd1);
        idle_inputs();

        // Idle cycles leave everything low and pointers untouched
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            check("s6_idle", 32'({s_wr_rdy, s_rd_rdy, s_rv, s_wr_en}), 32'd0);
        end
        wr0_valid = 1'b1; wr1_valid = 1'b1; rd0_valid = 1'b1; rd1_valid = 1'b1;
        step();
        check("s6_wr_ptr_held", 32'(s_wr_rdy), 32'd2);
        check("s6_rd_ptr_held", 32'(s_rd_rdy), 32'd2);
        idle_inputs();
        step();

        // Randomized traffic on a narrow address range to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            if (acc[0] || !wr0_valid) begin
                wr0_valid = ($urandom_range(0, 99) < 60);
                wr0_addr  = 8'($urandom_range(0, 7));
                wr0_data  = 16'($urandom);
            end
            if (acc[1] || !wr1_valid) begin
                wr1_valid = ($urandom_range(0, 99) < 60);
                wr1_addr  = 8'($urandom_range(0, 7));
                wr1_data  = 16'($urandom);
            end
            if (acc[2] || !rd0_valid) begin
                rd0_valid = ($urandom_range(0, 99) < 60);
                rd0_addr  = 8'($urandom_range(0, 7));
            end
            if (acc[3] || !rd1_valid) begin
                rd1_valid = ($urandom_range(0, 99) < 60);
                rd1_addr  = 8'($urandom_range(0, 7));
            end
            rst = ($urandom_range(0, 99) < 2);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
